regfile_scoreboard: RTL and testbench

Parametrised integer register file for the next-generation RISC-V core. It generalises the single-cycle register file in three ways: N read ports, configurable width and depth, and optional write-to-read bypass. It also adds a per-register busy scoreboard for pipelined hazard detection and a sequenced software-clear engine. It sits between decode (reads and issue) and writeback (writes).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard_bits.sv | 36 +++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file with busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  // Low bit of slot `port` inside a packed bus of `width`-bit slots.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy bits: one set port (issue), one clear port (writeback or
// clear engine), and NUM_RD combinational lookup ports. Bit 0 is never set.
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_en_i,
  input  logic [AW-1:0]        set_idx_i,
  input  logic                 clr_en_i,
  input  logic [AW-1:0]        clr_idx_i,
  input  logic [NUM_RD*AW-1:0] look_addr_i,
  output logic [NUM_RD-1:0]    look_busy_o
);

  logic [NUM_REGS-1:0] busy_q;

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      if (clr_en_i) busy_q[clr_idx_i] <= 1'b0;
      if (set_en_i && (set_idx_i != '0)) busy_q[set_idx_i] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_look
    assign look_busy_o[p] = busy_q[look_addr_i[port_lsb(p, AW) +: AW]];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with optional write bypass, busy
// scoreboard and a sequenced clear engine that zeroes x1..x(N-1).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  clr_state_t        state_q;
  logic [AW-1:0]     idx_q;
  logic              clr_busy_q;

  logic              wr_act;
  logic              issue_act;
  logic              sb_clr_en;
  logic [AW-1:0]     sb_clr_idx;
  logic [NUM_RD-1:0] sb_busy;

  // The clear engine owns the write and scoreboard-clear paths while running.
  assign wr_act     = wr_en && !clr_busy_q && (wr_addr != '0);
  assign issue_act  = issue_en && !clr_busy_q;
  assign sb_clr_en  = clr_busy_q || wr_act;
  assign sb_clr_idx = clr_busy_q ? idx_q : wr_addr;
  assign clr_busy   = clr_busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (clr_req) begin
            state_q    <= CLR_RUN;
            idx_q      <= AW'(1);
            clr_busy_q <= 1'b1;
          end
        end
        CLR_RUN: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(NUM_REGS - 1)) begin
            state_q    <= CLR_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= CLR_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (clr_busy_q) begin
      regs_q[idx_q] <= '0;
    end else if (wr_act) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard_bits #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .AW       (AW)
  ) u_bits (
    .clk_i       (clk),
    .rst_i       (reset),
    .set_en_i    (issue_act),
    .set_idx_i   (issue_rd),
    .clr_en_i    (sb_clr_en),
    .clr_idx_i   (sb_clr_idx),
    .look_addr_i (rd_addr),
    .look_busy_o (sb_busy)
  );

  // wr_act already excludes x0, so a hit never targets address 0.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_addr[port_lsb(p, AW) +: AW];
    assign hit  = (BYPASS != 0) && wr_act && (wr_addr == addr);
    assign rd_data[port_lsb(p, XLEN) +: XLEN] =
      (addr == '0) ? '0 : (hit ? wr_data : regs_q[addr]);
    assign rd_busy[p] = sb_busy[p] && !hit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances share stimulus
// and are checked against an array-based architectural model.
module tb_regfile_scoreboard;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int AW       = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NUM_RD-1:0]      rd_busy_b, rd_busy_n;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd;
  logic                   clr_req;
  logic                   clr_busy_b, clr_busy_n;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_rd(issue_rd), .clr_req(clr_req), .clr_busy(clr_busy_b)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_rd(issue_rd), .clr_req(clr_req), .clr_busy(clr_busy_n)
  );

  // Architectural model: register contents, busy flags, and which register the
  // clear engine wipes this cycle (0 = not clearing).
  logic [XLEN-1:0] m_regs [NUM_REGS];
  bit              m_busy [NUM_REGS];
  int              clr_pos;
  int              n_vec = 0;
  int              n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input bit byp, input int a);
    if (a == 0) return '0;
    if (byp && wr_en && clr_pos == 0 && int'(wr_addr) == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input bit byp, input int a);
    if (a == 0) return 1'b0;
    if (byp && wr_en && clr_pos == 0 && int'(wr_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic compare_all();
    for (int p = 0; p < NUM_RD; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      check($sformatf("rd_data_byp[%0d] x%0d", p, a), rd_data_b[p*XLEN +: XLEN], exp_data(1'b1, a));
      check($sformatf("rd_data_nobyp[%0d] x%0d", p, a), rd_data_n[p*XLEN +: XLEN], exp_data(1'b0, a));
      check($sformatf("rd_busy_byp[%0d] x%0d", p, a), rd_busy_b[p], exp_busy(1'b1, a));
      check($sformatf("rd_busy_nobyp[%0d] x%0d", p, a), rd_busy_n[p], exp_busy(1'b0, a));
    end
    check("clr_busy_byp", clr_busy_b, clr_pos != 0);
    check("clr_busy_nobyp", clr_busy_n, clr_pos != 0);
  endtask

  task automatic model_edge();
    if (clr_pos != 0) begin
      m_regs[clr_pos] = '0;
      m_busy[clr_pos] = 1'b0;
      clr_pos = (clr_pos == NUM_REGS - 1) ? 0 : clr_pos + 1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (clr_req) clr_pos = 1;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    clr_pos = 0;
  endtask

  task automatic set_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0; clr_req = 1'b0;
  endtask

  task automatic settle();
    #2;
    compare_all();
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    settle();
    clock();
  endtask

  // Asynchronous reset asserted between edges, then every address is read.
  task automatic do_reset();
    set_idle();
    #2 reset = 1'b1;
    #1 model_reset();
    check("clr_busy_on_reset", clr_busy_b, 1'b0);
    for (int a = 0; a < NUM_REGS; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1 compare_all();
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Same-cycle write visibility.
    rd_addr = {AW'(0), AW'(5)};
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    settle();
    check("byp_same_cycle", rd_data_b[XLEN-1:0], 32'hDEADBEEF);
    check("nobyp_same_cycle", rd_data_n[XLEN-1:0], 32'h0);
    clock();
    set_idle();
    settle();
    check("byp_next_cycle", rd_data_b[XLEN-1:0], 32'hDEADBEEF);
    check("nobyp_next_cycle", rd_data_n[XLEN-1:0], 32'hDEADBEEF);
    clock();

    // x0 is hardwired.
    rd_addr = '0;
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    issue_en = 1'b1; issue_rd = 0;
    cycle();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("x0_data", rd_data_b[XLEN-1:0], 32'h0);
      check("x0_busy", rd_busy_n[0], 1'b0);
      clock();
    end

    // Scoreboard set/clear priority.
    rd_addr = {AW'(7), AW'(7)};
    issue_en = 1'b1; issue_rd = 7;
    cycle();
    settle();
    check("busy_after_issue", rd_busy_b[0], 1'b1);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5_0007;
    clock();
    issue_en = 1'b0;
    settle();
    check("issue_beats_write", rd_busy_n[1], 1'b1);
    check("byp_write_hides_busy", rd_busy_b[0], 1'b0);
    check("nobyp_write_shows_busy", rd_busy_n[0], 1'b1);
    clock();
    set_idle();
    settle();
    check("busy_cleared_byp", rd_busy_b[0], 1'b0);
    check("busy_cleared_nobyp", rd_busy_n[0], 1'b0);
    clock();

    // Fill, then clear sequence with an ignored write and issue mid-clear.
    for (int r = 1; r < NUM_REGS; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = $urandom | 32'h1;
      issue_en = 1'b1; issue_rd = AW'(NUM_REGS - r);
      rd_addr = {AW'($urandom), AW'(r)};
      cycle();
    end
    set_idle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        wr_en = (i == 3); wr_addr = 3; wr_data = 32'hBAD0_0003;
        issue_en = (i == 4); issue_rd = 3;
        clr_req = (i == 6);
        rd_addr = {AW'(3), AW'($urandom)};
        settle();
        if (clr_busy_b) cnt++;
        clock();
      end
      check("clear_length", cnt, 31);
    end
    set_idle();
    for (int a = 0; a < NUM_REGS; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      settle();
      check("after_clear_data", rd_data_n[XLEN +: XLEN], 32'h0);
      check("after_clear_busy", rd_busy_n[1], 1'b0);
      clock();
    end

    // Reset ten cycles into a clear.
    for (int r = 1; r < NUM_REGS; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = $urandom | 32'h100;
      issue_en = 1'b1; issue_rd = AW'(r);
      cycle();
    end
    set_idle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = {AW'($urandom), AW'($urandom)};
      cycle();
    end
    do_reset();

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      rd_addr  = {AW'($urandom), AW'($urandom)};
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      issue_en = $urandom_range(0, 2) == 0;
      issue_rd = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      clr_req  = $urandom_range(0, 99) == 0;
      cycle();
    end
    set_idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
